// File: rtl/fetch_stage_if.sv
// Instruction-memory request channel between the fetch stage and imem.
// Request holds address stable until ImemReady; ImemReady completes the request in the same cycle.
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemRData;

  modport master (output ImemReq, output ImemAddr, input ImemReady, input ImemRData);
  modport slave  (input ImemReq, input ImemAddr, output ImemReady, output ImemRData);
endinterface

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: fetches from variable-latency imem, one instruction per cycle when imem is ready.
// Stalls park a returned word in a hold buffer; redirects drain any in-flight fetch before refetching.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [31:0]        PCTargetE,
  fetch_stage_if.master      imem,
  output logic [31:0]        PCF,
  output logic [31:0]        InstrD,
  output logic [31:0]        PCD,
  output logic [31:0]        PCPlus4D,
  output logic               ValidD
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] HELD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] imemAddr;
  logic [31:0] holdBuf;
  logic [31:0] fetchData;
  logic [31:0] pcPlus4F;
  logic        avail;
  logic        deliver;

  assign imem.ImemReq  = (state == REQ) || (state == DRAIN);
  assign imem.ImemAddr = imemAddr;

  always_comb begin
    pcPlus4F  = PCF + 32'd4;
    avail     = ((state == REQ) && imem.ImemReady) || (state == HELD);
    deliver   = avail && !StallF && !StallD && !FlushD && !PCSrcE;
    fetchData = (state == HELD) ? holdBuf : imem.ImemRData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PCF <= RESET_PC;
    end else if (PCSrcE) begin
      PCF <= PCTargetE;
    end else if (deliver) begin
      PCF <= pcPlus4F;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      imemAddr <= RESET_PC;
      holdBuf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imemAddr <= PCSrcE ? PCTargetE : PCF;
        end
        REQ: begin
          if (PCSrcE) begin
            // A redirect that lands mid-wait must still let the old request finish.
            if (imem.ImemReady) imemAddr <= PCTargetE;
            else                state    <= DRAIN;
          end else if (imem.ImemReady) begin
            if (deliver) begin
              imemAddr <= pcPlus4F;
            end else begin
              state   <= HELD;
              holdBuf <= imem.ImemRData;
            end
          end
        end
        HELD: begin
          if (PCSrcE) begin
            state    <= REQ;
            imemAddr <= PCTargetE;
            holdBuf  <= '0;
          end else if (deliver) begin
            state    <= REQ;
            imemAddr <= pcPlus4F;
          end
        end
        DRAIN: begin
          // PCF already tracks the newest redirect target, so it is the refetch address.
          if (imem.ImemReady) begin
            state    <= REQ;
            imemAddr <= PCSrcE ? PCTargetE : PCF;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (deliver) begin
      InstrD   <= fetchData;
      PCD      <= PCF;
      PCPlus4D <= pcPlus4F;
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipeline IF stage plus IF/ID register for the 5-stage RV32I core; sits directly upstream of decode and is the consumer of the hazard unit's StallF, StallD, FlushD and of PCSrcE/PCTargetE from execute.
- Holds PCF and issues requests to an instruction memory with variable latency (req/ready handshake).
- Buffers a returned instruction while decode is stalled.
- Discards in-flight fetches after a taken branch/jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) inserted into decode on bubbles and flushes.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- StallF  input  1  from hazard unit; holds PCF.
- StallD  input  1  from hazard unit; holds the IF/ID register.
- FlushD  input  1  from hazard unit; clears the IF/ID register.
- PCSrcE  input  1  taken branch/jump resolved in execute.
- PCTargetE  input  32  redirect target.
- ImemReq  output  1  request valid.
- ImemAddr  output  32  request address (registered).
- ImemReady  input  1  data valid / request complete, same cycle.
- ImemRData  input  32  instruction word, valid when ImemReady=1.
- PCF  output  32  current fetch PC.
- InstrD  output  32  decode instruction.
- PCD  output  32  decode PC.
- PCPlus4D  output  32  PCD+4.
- ValidD  output  1  InstrD is a real instruction.

Behaviour:
- Reset (async, rst=0):
  - PCF=ImemAddr=RESET_PC, state=IDLE, ImemReq=0.
  - InstrD=NOP_INSTR, PCD=PCPlus4D=0, ValidD=0, hold buffer cleared.
- State machine: IDLE, REQ, HELD, DRAIN. ImemReq = (state==REQ || state==DRAIN), driven from state only.
- IDLE: next cycle -> REQ with ImemAddr=PCF. Entered only from reset.
- Handshake: while ImemReq=1 and ImemReady=0, ImemAddr holds stable. A request completes on the cycle ImemReady=1. ImemReady while ImemReq=0 is ignored.
- Define avail = (state==REQ && ImemReady) || state==HELD.
- Define deliver = avail && !StallF && !StallD && !FlushD && !PCSrcE.
- Data source on deliver: HELD buffer if state==HELD, otherwise ImemRData.
- IF/ID register, priority order each cycle:
  1. FlushD=1: load NOP_INSTR, ValidD=0, PCD=PCPlus4D=0.
  2. Else StallD=1: hold all D outputs.
  3. Else deliver: InstrD=data, PCD=PCF, PCPlus4D=PCF+4, ValidD=1.
  4. Else: bubble (NOP_INSTR, ValidD=0, PCD=PCPlus4D=0).
- PCF update, priority order:
  1. PCSrcE=1: PCF <= PCTargetE (overrides StallF).
  2. Else deliver: PCF <= PCF+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  3. Else hold.
- Transitions without redirect (PCSrcE=0):
  - REQ, ImemReady=0: stay REQ.
  - REQ, ImemReady=1, deliver: stay REQ, ImemAddr <= PCF+4 (back-to-back, no idle cycle).
  - REQ, ImemReady=1, not deliver: -> HELD, buffer <= ImemRData, ImemReq drops.
  - HELD, deliver: -> REQ, ImemAddr <= PCF+4.
  - HELD, no deliver: stay HELD, buffer held.
- Transitions with redirect (PCSrcE=1); returned/buffered data is never delivered:
  - REQ, ImemReady=0: -> DRAIN; ImemAddr keeps the old address until completion.
  - REQ, ImemReady=1: stay REQ, ImemAddr <= PCTargetE, returned data dropped.
  - HELD: -> REQ, ImemAddr <= PCTargetE, buffer discarded.
  - DRAIN, ImemReady=0: stay DRAIN; PCF takes the newest target.
  - DRAIN, ImemReady=1: -> REQ with ImemAddr <= the newest target.
- DRAIN without redirect:
  - ImemReady=0: stay DRAIN.
  - ImemReady=1: discard data, -> REQ, ImemAddr <= PCF.
- ValidD is never 1 for any word requested before the most recent redirect.
- Reset mid-request: everything returns to reset values immediately. The memory-side transaction is abandoned; any ImemReady arriving while state==IDLE is ignored.

Test Plan:
- Reset release, ImemReady tied 1 -> ImemReq=0 in the first post-reset cycle; then PCD=0,4,8,… on consecutive cycles with ValidD=1, RESET_PC=0.
- ImemReady low 3 cycles per request -> ImemAddr stable during the wait; 3 bubble cycles (InstrD=32'h13, ValidD=0) between valid instructions.
- StallF=StallD=1 on the cycle data 32'hDEAD_BEEF returns -> state HELD, ImemReq=0, D outputs unchanged. After the stall drops, InstrD=32'hDEAD_BEEF with the correct PCD; the next request is at PCD+4.
- PCSrcE=1, PCTargetE=32'h100, FlushD=1 while a request to 32'h20 is outstanding -> DRAIN; returned data for 32'h20 is dropped with ValidD=0. Next ImemAddr=32'h100, then PCD=32'h100, ValidD=1.
- Two redirects (0x100, then 0x200) during one DRAIN -> the only post-drain fetch is 32'h200.
- PCF=32'hFFFF_FFFC delivered -> PCPlus4D=0, PCF wraps to 0. Assert rst=0 mid-wait -> all outputs at reset values in the same cycle.
